// File: rtl/add_sub_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : add_sub_pipe                                                |
// | Brief    : Pipelined two's-complement adder/subtractor, SLICE bits of  |
// |            carry chain per stage, valid/ready, saturation and flags.   |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module add_sub_pipe #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_L = WIDTH / SLICE;

    // Stage k holds an operation whose slices below k are already resolved.
    logic             r_v   [c_L];
    logic [WIDTH-1:0] r_a   [c_L];
    logic [WIDTH-1:0] r_b   [c_L];
    logic [WIDTH-1:0] r_sum [c_L];
    logic             r_c   [c_L];
    logic             r_sat [c_L];

    logic [SLICE:0]   w_slice [c_L];
    logic [WIDTH-1:0] w_sum   [c_L];
    logic             w_stall;
    logic [WIDTH-1:0] w_raw;
    logic             w_cout;
    logic             w_ovf;
    logic             w_a_msb;
    logic [WIDTH-1:0] w_s;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    always_comb begin
        for (int k = 0; k < c_L; k++) begin
            w_slice[k] = {1'b0, r_a[k][k*SLICE +: SLICE]}
                       + {1'b0, r_b[k][k*SLICE +: SLICE]}
                       + {{SLICE{1'b0}}, r_c[k]};
            w_sum[k] = r_sum[k];
            w_sum[k][k*SLICE +: SLICE] = w_slice[k][SLICE-1:0];
        end
    end

    assign w_raw   = w_sum[c_L-1];
    assign w_cout  = w_slice[c_L-1][SLICE];
    assign w_a_msb = r_a[c_L-1][WIDTH-1];
    assign w_ovf   = (w_a_msb == r_b[c_L-1][WIDTH-1]) && (w_raw[WIDTH-1] != w_a_msb);

    always_comb begin
        w_s = w_raw;
        if (r_sat[c_L-1] && w_ovf) begin
            w_s = w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_L; k++) begin
                r_v[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_sat[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (!w_stall) begin
            // Subtraction folds into the add as inverted B plus carry-in.
            r_v[0]   <= in_valid;
            r_a[0]   <= a;
            r_b[0]   <= b ^ {WIDTH{sub}};
            r_sum[0] <= '0;
            r_c[0]   <= sub;
            r_sat[0] <= sat;
            for (int k = 1; k < c_L; k++) begin
                r_v[k]   <= r_v[k-1];
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_sum[k] <= w_sum[k-1];
                r_c[k]   <= w_slice[k-1][SLICE];
                r_sat[k] <= r_sat[k-1];
            end
            out_valid <= r_v[c_L-1];
            if (r_v[c_L-1]) begin
                s    <= w_s;
                cout <= w_cout;
                ovf  <= w_ovf;
                zero <= (w_s == '0);
            end
        end
    end

endmodule
`default_nettype wire
